// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//
// AXI4 memory responder that terminates the dcache refill/writeback and bypass
// ports in standalone and unit-level configurations. It serves INCR, WRAP and
// FIXED bursts from an internal word-addressed array, one transaction at a
// time, alternates fairly between reads and writes, and keeps a single-entry
// exclusive monitor for LR/SC-style accesses.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   axi_req_i  AW/W/AR channels plus b_ready and r_ready from the initiator
//   axi_rsp_o  aw_ready/ar_ready/w_ready plus the B and R channels
//
// Handshakes: every channel transfers on a cycle where valid and ready are both
// high at the rising clock edge. r_valid and b_valid, once raised, hold with a
// stable payload until the matching ready is seen.
//
// The FSM state is available as the internal signal 'state' for checkers.

package config_pkg;

  typedef struct packed {
    int unsigned AxiAddrWidth;
    int unsigned AxiDataWidth;
    int unsigned AxiIdWidth;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    AxiAddrWidth: 64,
    AxiDataWidth: 64,
    AxiIdWidth:   4
  };

  // Channel structs matching cva6_cfg_empty; a real system overrides the
  // type parameters with its own AXI typedefs.
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
  } default_axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } default_axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } default_axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } default_axi_r_t;

  typedef struct packed {
    default_axi_ax_t aw;
    logic            aw_valid;
    default_axi_w_t  w;
    logic            w_valid;
    logic            b_ready;
    default_axi_ax_t ar;
    logic            ar_valid;
    logic            r_ready;
  } default_axi_req_t;

  typedef struct packed {
    logic           aw_ready;
    logic           ar_ready;
    logic           w_ready;
    logic           b_valid;
    default_axi_b_t b;
    logic           r_valid;
    default_axi_r_t r;
  } default_axi_rsp_t;

endpackage

module axi_mem_responder #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type axi_req_t = config_pkg::default_axi_req_t,
  parameter type axi_rsp_t = config_pkg::default_axi_rsp_t,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned ResvBytes = 16
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);

  localparam int unsigned AW   = CVA6Cfg.AxiAddrWidth;
  localparam int unsigned DW   = CVA6Cfg.AxiDataWidth;
  localparam int unsigned IW   = CVA6Cfg.AxiIdWidth;
  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned IdxW = $clog2(NumWords);

  localparam logic [AW-1:0] ByteLimit = AW'(NumWords * NB);
  localparam logic [AW-1:0] ResvMask  = ~AW'(ResvBytes - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ       = 2'd1;
  localparam logic [1:0] WRITE      = 2'd2;
  localparam logic [1:0] WRITE_RESP = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]    state;
  logic          prio_rd;
  logic [IW-1:0] id_q;
  logic [AW-1:0] cur_addr;
  logic [7:0]    len_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic          lock_q;
  logic [7:0]    cnt;
  logic          wr_err;
  logic          excl_ok;
  logic          resv_valid;
  logic [AW-1:0] resv_addr;
  logic [IW-1:0] resv_id;

  logic [DW-1:0] mem [NumWords];

  logic            ar_hs;
  logic            aw_hs;
  logic            in_range;
  logic            last_beat;
  logic [IdxW-1:0] word_idx;
  logic [AW-1:0]   addr_next;

  // WRAP keeps the bits above the wrap boundary and lets the bits below it
  // count modulo the boundary; len+1 is a power of two for legal WRAP bursts.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                               input logic [2:0]    sz,
                                               input logic [1:0]    bt,
                                               input logic [7:0]    ln);
    logic [AW-1:0] step;
    logic [AW-1:0] wrap_mask;
    step      = AW'(1) << sz;
    wrap_mask = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
    case (bt)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~wrap_mask) | ((a + step) & wrap_mask);
      default:     next_addr = a + step;
    endcase
  endfunction

  // Arbitration only happens in IDLE; prio_rd breaks ties and flips after
  // every grant so coincident requests alternate.
  assign ar_hs     = (state == IDLE) && axi_req_i.ar_valid && (!axi_req_i.aw_valid || prio_rd);
  assign aw_hs     = (state == IDLE) && axi_req_i.aw_valid && (!axi_req_i.ar_valid || !prio_rd);
  assign in_range  = cur_addr < ByteLimit;
  assign last_beat = (cnt == len_q);
  assign word_idx  = cur_addr[OffW +: IdxW];
  assign addr_next = next_addr(cur_addr, size_q, burst_q, len_q);

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.ar_ready = ar_hs;
    axi_rsp_o.aw_ready = aw_hs;
    axi_rsp_o.w_ready  = (state == WRITE);
    axi_rsp_o.r_valid  = (state == READ);
    axi_rsp_o.b_valid  = (state == WRITE_RESP);
    if (state == READ) begin
      axi_rsp_o.r.id   = id_q;
      axi_rsp_o.r.last = last_beat;
      if (in_range) begin
        axi_rsp_o.r.data = mem[word_idx];
        axi_rsp_o.r.resp = lock_q ? RESP_EXOKAY : RESP_OKAY;
      end else begin
        axi_rsp_o.r.resp = RESP_SLVERR;
      end
    end
    if (state == WRITE_RESP) begin
      axi_rsp_o.b.id = id_q;
      if (wr_err) begin
        axi_rsp_o.b.resp = RESP_SLVERR;
      end else if (lock_q && excl_ok) begin
        axi_rsp_o.b.resp = RESP_EXOKAY;
      end else begin
        axi_rsp_o.b.resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      prio_rd    <= 1'b1;
      id_q       <= '0;
      cur_addr   <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      lock_q     <= 1'b0;
      cnt        <= '0;
      wr_err     <= 1'b0;
      excl_ok    <= 1'b0;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
      resv_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            id_q     <= axi_req_i.ar.id;
            cur_addr <= axi_req_i.ar.addr;
            len_q    <= axi_req_i.ar.len;
            size_q   <= axi_req_i.ar.size;
            burst_q  <= axi_req_i.ar.burst;
            lock_q   <= axi_req_i.ar.lock;
            cnt      <= '0;
            prio_rd  <= 1'b0;
            state    <= READ;
            if (axi_req_i.ar.lock) begin
              resv_valid <= 1'b1;
              resv_addr  <= axi_req_i.ar.addr & ResvMask;
              resv_id    <= axi_req_i.ar.id;
            end
          end else if (aw_hs) begin
            id_q     <= axi_req_i.aw.id;
            cur_addr <= axi_req_i.aw.addr;
            len_q    <= axi_req_i.aw.len;
            size_q   <= axi_req_i.aw.size;
            burst_q  <= axi_req_i.aw.burst;
            lock_q   <= axi_req_i.aw.lock;
            cnt      <= '0;
            wr_err   <= 1'b0;
            // The reservation cannot change while this write is in flight,
            // so the exclusive verdict is settled at address time.
            excl_ok  <= resv_valid &&
                        ((axi_req_i.aw.addr & ResvMask) == resv_addr) &&
                        (axi_req_i.aw.id == resv_id);
            prio_rd  <= 1'b1;
            state    <= WRITE;
          end
        end
        READ: begin
          if (axi_req_i.r_ready) begin
            cnt      <= cnt + 8'd1;
            cur_addr <= addr_next;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          if (axi_req_i.w_valid) begin
            cnt      <= cnt + 8'd1;
            cur_addr <= addr_next;
            if ((axi_req_i.w.last != last_beat) || !in_range) begin
              wr_err <= 1'b1;
            end
            if (!lock_q && ((cur_addr & ResvMask) == resv_addr)) begin
              resv_valid <= 1'b0;
            end
            if (last_beat) begin
              state <= WRITE_RESP;
              if (lock_q && excl_ok) begin
                resv_valid <= 1'b0;
              end
            end
          end
        end
        WRITE_RESP: begin
          if (axi_req_i.b_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a failed exclusive store writes nothing.
  always_ff @(posedge clk_i) begin
    if ((state == WRITE) && axi_req_i.w_valid && in_range && (!lock_q || excl_ok)) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (axi_req_i.w.strb[b]) begin
          mem[word_idx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder
//
// Bench for axi_mem_responder: directed scenarios followed by random traffic.
// Driver tasks issue transactions one at a time; a reference model computes the
// expected R beats and B responses when each transaction is issued and queues
// them; a monitor pops and compares on every R/B handshake.

module tb_axi_mem_responder;
  import config_pkg::*;

  localparam int          NW     = 256;
  localparam logic [63:0] NBYTES = 64'(NW * 8);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  default_axi_req_t req;
  default_axi_rsp_t rsp;

  int checks = 0;
  int errors = 0;

  // R entry: {last, resp, id, data}; B entry: {id, resp}
  logic [70:0] exp_r_q[$];
  logic [5:0]  exp_b_q[$];
  logic [70:0] r_exp;
  logic [5:0]  b_exp;

  // reference model state
  logic [63:0] mem_m [NW];
  bit          resv_v = 1'b0;
  logic [63:0] resv_a = '0;
  logic [3:0]  resv_id = '0;

  // write data staged for the next write transaction
  logic [63:0] wdata [256];
  logic [7:0]  wstrb [256];
  logic        wlast [256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  axi_mem_responder #(
    .CVA6Cfg  (cva6_cfg_empty),
    .axi_req_t(default_axi_req_t),
    .axi_rsp_t(default_axi_rsp_t),
    .NumWords (NW),
    .ResvBytes(16)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .axi_req_i(req),
    .axi_rsp_o(rsp)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] next_beat(input logic [63:0] a, input int size,
                                            input int burst, input int len);
    logic [63:0] step;
    logic [63:0] bsz;
    logic [63:0] base;
    step = 64'(1) << size;
    if (burst == 0) return a;
    if (burst == 1) return a + step;
    bsz  = step * 64'(len + 1);
    base = (a / bsz) * bsz;
    return base + ((a - base + step) % bsz);
  endfunction

  function automatic logic [63:0] granule(input logic [63:0] a);
    return a & ~64'(15);
  endfunction

  task automatic read_model(input int id, input logic [63:0] addr, input int len,
                            input int size, input int burst, input bit lock);
    logic [63:0] a;
    logic [63:0] d;
    logic [1:0]  resp;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      if (a < NBYTES) begin
        d    = mem_m[int'(a / 8)];
        resp = lock ? 2'b01 : 2'b00;
      end else begin
        d    = '0;
        resp = 2'b10;
      end
      exp_r_q.push_back({(i == len), resp, 4'(id), d});
      a = next_beat(a, size, burst, len);
    end
    if (lock) begin
      resv_v  = 1'b1;
      resv_a  = granule(addr);
      resv_id = 4'(id);
    end
  endtask

  task automatic write_model(input int id, input logic [63:0] addr, input int len,
                             input int size, input int burst, input bit lock);
    logic [63:0] a;
    bit ok;
    bit err;
    a   = addr;
    err = 1'b0;
    ok  = lock && resv_v && (granule(addr) == resv_a) && (4'(id) == resv_id);
    for (int i = 0; i <= len; i++) begin
      if (wlast[i] != (i == len)) err = 1'b1;
      if (a >= NBYTES) begin
        err = 1'b1;
      end else if (!lock || ok) begin
        for (int b = 0; b < 8; b++)
          if (wstrb[i][b]) mem_m[int'(a / 8)][b*8 +: 8] = wdata[i][b*8 +: 8];
      end
      if (!lock && (granule(a) == resv_a)) resv_v = 1'b0;
      a = next_beat(a, size, burst, len);
    end
    if (ok) resv_v = 1'b0;
    exp_b_q.push_back({4'(id), err ? 2'b10 : (ok ? 2'b01 : 2'b00)});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp.r_valid && req.r_ready) begin
        if (exp_r_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: got beat %0h expected none", rsp.r.data);
        end else begin
          r_exp = exp_r_q.pop_front();
          check("r_beat", {rsp.r.last, rsp.r.resp, rsp.r.id, rsp.r.data}, r_exp);
        end
      end
      if (rsp.b_valid && req.b_ready) begin
        if (exp_b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got resp %0h expected none", rsp.b.resp);
        end else begin
          b_exp = exp_b_q.pop_front();
          check("b_resp", {rsp.b.id, rsp.b.resp}, b_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic set_ar(input int id, input logic [63:0] addr, input int len,
                        input int size, input int burst, input bit lock);
    req.ar.id = 4'(id); req.ar.addr = addr; req.ar.len = 8'(len);
    req.ar.size = 3'(size); req.ar.burst = 2'(burst); req.ar.lock = lock;
  endtask

  task automatic set_aw(input int id, input logic [63:0] addr, input int len,
                        input int size, input int burst, input bit lock);
    req.aw.id = 4'(id); req.aw.addr = addr; req.aw.len = 8'(len);
    req.aw.size = 3'(size); req.aw.burst = 2'(burst); req.aw.lock = lock;
  endtask

  task automatic fill_w(input int len, input bit rand_strb, input int bad_beat);
    for (int i = 0; i <= len; i++) begin
      wdata[i] = {$urandom, $urandom};
      wstrb[i] = rand_strb ? 8'($urandom_range(0, 255)) : 8'hFF;
      wlast[i] = (i == len) ^ (i == bad_beat);
    end
  endtask

  task automatic wait_ar_hs();
    bit got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp.ar_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("ar_handshake", got, 1'b1);
    if (got) begin @(posedge clk); #1; end
    req.ar_valid = 1'b0;
  endtask

  task automatic wait_aw_hs();
    bit got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp.aw_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("aw_handshake", got, 1'b1);
    if (got) begin @(posedge clk); #1; end
    req.aw_valid = 1'b0;
  endtask

  task automatic r_phase(input int len, input bit hold);
    int beats = 0;
    int cyc = 0;
    bit first = 1'b1;
    while (beats < len + 1 && cyc < 400) begin
      req.r_ready = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (first) begin check("r_latency", rsp.r_valid, 1'b1); first = 1'b0; end
      if (rsp.r_valid && req.r_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    req.r_ready = 1'b0;
    check("r_beat_count", beats, len + 1);
    if (hold) check("r_duration", cyc, len + 1);
    check("r_turnaround", dut.state, 2'd0);
  endtask

  task automatic w_phase(input int len);
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req.w_valid = 1'b0;
        @(posedge clk); #1;
      end
      req.w_valid = 1'b1;
      req.w.data = wdata[i];
      req.w.strb = wstrb[i];
      req.w.last = wlast[i];
      @(negedge clk);
      check("w_ready", rsp.w_ready, 1'b1);
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0;
  endtask

  task automatic b_phase();
    bit done = 1'b0;
    bit first = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      req.b_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (first) begin check("b_latency", rsp.b_valid, 1'b1); first = 1'b0; end
      if (rsp.b_valid && req.b_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req.b_ready = 1'b0;
    check("b_done", done, 1'b1);
    check("b_turnaround", dut.state, 2'd0);
  endtask

  task automatic do_read(input int id, input logic [63:0] addr, input int len,
                         input int size, input int burst, input bit lock, input bit hold);
    set_ar(id, addr, len, size, burst, lock);
    req.ar_valid = 1'b1;
    read_model(id, addr, len, size, burst, lock);
    wait_ar_hs();
    r_phase(len, hold);
  endtask

  task automatic do_write(input int id, input logic [63:0] addr, input int len,
                          input int size, input int burst, input bit lock);
    set_aw(id, addr, len, size, burst, lock);
    req.aw_valid = 1'b1;
    write_model(id, addr, len, size, burst, lock);
    wait_aw_hs();
    w_phase(len);
    b_phase();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ready", rsp.ar_ready, 1'b0);
    check("rst_aw_ready", rsp.aw_ready, 1'b0);
    check("rst_w_ready", rsp.w_ready, 1'b0);
    check("rst_r_valid", rsp.r_valid, 1'b0);
    check("rst_b_valid", rsp.b_valid, 1'b0);
    check("rst_state", dut.state, 2'd0);
    check("rst_prio_rd", dut.prio_rd, 1'b1);
    check("rst_resv_valid", dut.resv_valid, 1'b0);
    check("rst_cnt", dut.cnt, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Coincident AR/AW straight out of reset: AR first, then AW.
    set_ar(1, NBYTES, 0, 3, 1, 1'b0);
    set_aw(3, 64'h100, 0, 3, 1, 1'b0);
    fill_w(0, 1'b0, -1);
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    @(negedge clk);
    check("arb1_ar_ready", rsp.ar_ready, 1'b1);
    check("arb1_aw_ready", rsp.aw_ready, 1'b0);
    read_model(1, NBYTES, 0, 3, 1, 1'b0);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    r_phase(0, 1'b0);
    req.ar_valid = 1'b1;
    @(negedge clk);
    check("arb2_aw_ready", rsp.aw_ready, 1'b1);
    check("arb2_ar_ready", rsp.ar_ready, 1'b0);
    write_model(3, 64'h100, 0, 3, 1, 1'b0);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    w_phase(0);
    b_phase();
    read_model(1, NBYTES, 0, 3, 1, 1'b0);
    wait_ar_hs();
    r_phase(0, 1'b0);

    // Preload the whole array; words 0..15 carry 0x1000+i.
    for (int blk = 0; blk < NW / 16; blk++) begin
      fill_w(15, 1'b0, -1);
      if (blk == 0) for (int i = 0; i < 16; i++) wdata[i] = 64'h1000 + 64'(i);
      do_write(0, 64'(blk * 128), 15, 3, 1, 1'b0);
    end

    // 16-beat INCR refill with r_ready held high.
    do_read(0, 64'h0, 15, 3, 1, 1'b0, 1'b1);
    // WRAP: 0x18, 0x00, 0x08, 0x10
    do_read(1, 64'h18, 3, 3, 2, 1'b0, 1'b0);

    // Exclusive pair that succeeds.
    do_read(2, 64'h40, 0, 3, 1, 1'b1, 1'b0);
    fill_w(0, 1'b0, -1);
    do_write(2, 64'h48, 0, 3, 1, 1'b1);
    do_read(0, 64'h48, 0, 3, 1, 1'b0, 1'b0);

    // Exclusive pair broken by a normal write into the granule.
    do_read(2, 64'h40, 0, 3, 1, 1'b1, 1'b0);
    fill_w(0, 1'b0, -1);
    wstrb[0] = 8'hF0;
    do_write(0, 64'h44, 0, 2, 1, 1'b0);
    fill_w(0, 1'b0, -1);
    do_write(2, 64'h48, 0, 3, 1, 1'b1);
    do_read(0, 64'h48, 0, 3, 1, 1'b0, 1'b0);

    // Errors and strobes.
    do_read(1, NBYTES, 0, 3, 1, 1'b0, 1'b0);
    fill_w(1, 1'b0, 0);
    do_write(0, 64'h300, 1, 3, 1, 1'b0);
    fill_w(0, 1'b0, -1);
    wstrb[0] = 8'h0F;
    do_write(0, 64'h380, 0, 3, 1, 1'b0);
    do_read(0, 64'h380, 0, 3, 1, 1'b0, 1'b0);
    do_write(5, NBYTES - 64'h10, 3, 3, 1, 1'b0);
    do_read(5, NBYTES - 64'h10, 3, 3, 1, 1'b0, 1'b0);

    // Reset in the middle of an 8-beat write: three beats land.
    fill_w(7, 1'b0, -1);
    set_aw(0, 64'h200, 7, 3, 1, 1'b0);
    req.aw_valid = 1'b1;
    wait_aw_hs();
    for (int i = 0; i < 3; i++) begin
      req.w_valid = 1'b1;
      req.w.data = wdata[i];
      req.w.strb = wstrb[i];
      req.w.last = wlast[i];
      @(posedge clk); #1;
      mem_m[64 + i] = wdata[i];
    end
    req.w_valid = 1'b0;
    rst_n = 1'b0;
    resv_v = 1'b0;
    @(negedge clk);
    check("midrst_state", dut.state, 2'd0);
    check("midrst_w_ready", rsp.w_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(0, 64'h200, 7, 3, 1, 1'b0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      int burst, size, len, id;
      bit lock;
      logic [63:0] addr;
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 3);
      len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 7);
      id    = $urandom_range(0, 3);
      lock  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) addr = NBYTES - 64'($urandom_range(0, 32));
      else addr = 64'($urandom_range(0, NW * 8 - 1));
      if (lock && resv_v && $urandom_range(0, 1) == 1) begin
        addr = resv_a + 64'($urandom_range(0, 15));
        id   = int'(resv_id);
      end
      addr = addr & ~((64'(1) << size) - 64'(1));
      if ($urandom_range(0, 1) == 0) begin
        do_read(id, addr, len, size, burst, lock, 1'b0);
      end else begin
        fill_w(len, 1'b1, ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1);
        do_write(id, addr, len, size, burst, lock);
      end
    end

    repeat (3) @(posedge clk);
    check("r_queue_empty", exp_r_q.size(), 0);
    check("b_queue_empty", exp_b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
